// File: rtl/dcf77_pulse_decoder.sv
// Purpose: DCF77 front end - synchronise, majority-filter, measure pulse/gap widths, emit bits and minute marks.
// Latency: raw edge to strobe = 2 qzt_clk (sync) + 2 ticks (filter) + 1 qzt_clk (output register).
// Backpressure: none; every strobe is a single qzt_clk cycle and must be taken when asserted.
//
// Ports:
//   qzt_clk, reset      system clock, asynchronous active-high reset
//   tick_1khz           one-cycle 1 kHz enable; all logic past the synchroniser advances only on it
//   sgn_in              raw demodulated DCF77 signal (asynchronous, high = pulse)
//   bit_valid/bit_value decoded bit strobe; value held until the next strobe
//   minute_mark         strobe at the rising edge that opens second 0
//   frame_ok            strobe with minute_mark when the finished frame had 59 clean bits
//   err                 strobe on pulse width violation or signal timeout
//   bit_count           bits accepted since the last minute mark (saturates at 63)
//   state_dbg           FSM state: IDLE=0, HIGH=1, LOW=2
module dcf77_pulse_decoder #(
  parameter int ZERO_MIN = 40,
  parameter int ZERO_MAX = 130,
  parameter int ONE_MIN  = 150,
  parameter int ONE_MAX  = 250,
  parameter int GAP_MIN  = 1500,
  parameter int TIMEOUT  = 2500,
  parameter int CNT_W    = 12     // must hold TIMEOUT+1 (width+1 is compared)
) (
  input  logic       qzt_clk,
  input  logic       reset,
  input  logic       tick_1khz,
  input  logic       sgn_in,
  output logic       bit_valid,
  output logic       bit_value,
  output logic       minute_mark,
  output logic       frame_ok,
  output logic       err,
  output logic [5:0] bit_count,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] K_ZMIN = CNT_W'(ZERO_MIN);
  localparam logic [CNT_W-1:0] K_ZMAX = CNT_W'(ZERO_MAX);
  localparam logic [CNT_W-1:0] K_OMIN = CNT_W'(ONE_MIN);
  localparam logic [CNT_W-1:0] K_OMAX = CNT_W'(ONE_MAX);
  localparam logic [CNT_W-1:0] K_GAP  = CNT_W'(GAP_MIN);
  localparam logic [CNT_W-1:0] K_TOUT = CNT_W'(TIMEOUT);

  logic [1:0]       sync_q;
  logic [2:0]       hist_q;
  logic             filt;
  logic             filt_q;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] w1;
  logic             timeout;

  state_t     state_q, state_d;
  logic       frame_bad_q, frame_bad_d;
  logic       bit_valid_d, bit_value_d, minute_mark_d, frame_ok_d, err_d;
  logic [5:0] bit_count_d;

  // Two-flop synchroniser for the asynchronous antenna signal.
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], sgn_in};
  end

  // Majority of three tick samples: a lone one-tick glitch never flips filt,
  // and both edges are delayed equally so measured widths are preserved.
  assign filt = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      hist_q <= 3'b000;
      filt_q <= 1'b0;
    end else if (tick_1khz) begin
      hist_q <= {hist_q[1:0], sync_q[1]};
      filt_q <= filt;
    end
  end

  assign rise = tick_1khz &  filt & ~filt_q;
  assign fall = tick_1khz & ~filt &  filt_q;

  // width_q counts ticks since the last edge; the deciding tick itself is
  // included by comparing width+1.
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      width_q <= '0;
    end else if (tick_1khz) begin
      if (rise || fall)         width_q <= '0;
      else if (width_q != K_TOUT) width_q <= width_q + CNT_W'(1);
    end
  end

  assign w1      = width_q + CNT_W'(1);
  assign timeout = tick_1khz & (w1 >= K_TOUT);

  always_comb begin
    state_d       = state_q;
    frame_bad_d   = frame_bad_q;
    bit_valid_d   = 1'b0;
    bit_value_d   = bit_value;
    minute_mark_d = 1'b0;
    frame_ok_d    = 1'b0;
    err_d         = 1'b0;
    bit_count_d   = bit_count;

    case (state_q)
      IDLE: begin
        // Preceding gap unknown: just synchronise to the pulse.
        if (rise) state_d = HIGH;
      end
      HIGH: begin
        if (timeout) begin
          err_d       = 1'b1;
          frame_bad_d = 1'b1;
          state_d     = IDLE;
        end else if (fall) begin
          if (w1 >= K_ZMIN && w1 <= K_ZMAX) begin
            bit_valid_d = 1'b1;
            bit_value_d = 1'b0;
            if (bit_count != 6'd63) bit_count_d = bit_count + 6'd1;
          end else if (w1 >= K_OMIN && w1 <= K_OMAX) begin
            bit_valid_d = 1'b1;
            bit_value_d = 1'b1;
            if (bit_count != 6'd63) bit_count_d = bit_count + 6'd1;
          end else begin
            err_d       = 1'b1;
            frame_bad_d = 1'b1;
          end
          state_d = LOW;
        end
      end
      LOW: begin
        if (timeout) begin
          err_d       = 1'b1;
          frame_bad_d = 1'b1;
          state_d     = IDLE;
        end else if (rise) begin
          if (w1 >= K_GAP) begin
            minute_mark_d = 1'b1;
            frame_ok_d    = ~frame_bad_q && (bit_count == 6'd59);
            bit_count_d   = 6'd0;
            frame_bad_d   = 1'b0;
          end
          state_d = HIGH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      frame_bad_q <= 1'b1;   // the partial frame after reset can never be ok
      bit_valid   <= 1'b0;
      bit_value   <= 1'b0;
      minute_mark <= 1'b0;
      frame_ok    <= 1'b0;
      err         <= 1'b0;
      bit_count   <= 6'd0;
    end else begin
      state_q     <= state_d;
      frame_bad_q <= frame_bad_d;
      bit_valid   <= bit_valid_d;
      bit_value   <= bit_value_d;
      minute_mark <= minute_mark_d;
      frame_ok    <= frame_ok_d;
      err         <= err_d;
      bit_count   <= bit_count_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_dcf77_pulse_decoder.sv
// Purpose: directed bench for dcf77_pulse_decoder - table of pulse/gap records plus hand sequences.
// Latency: one record = hi ticks high then lo ticks low; every tick lasts two qzt_clk cycles.
// Backpressure: none; a negedge monitor counts strobes and the stimulus compares deltas per record.
module tb_dcf77_pulse_decoder;

  logic       qzt_clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1khz = 1'b0;
  logic       sgn_in = 1'b0;
  logic       bit_valid, bit_value, minute_mark, frame_ok, err;
  logic [5:0] bit_count;
  logic [1:0] state_dbg;

  dcf77_pulse_decoder dut (
    .qzt_clk     (qzt_clk),
    .reset       (reset),
    .tick_1khz   (tick_1khz),
    .sgn_in      (sgn_in),
    .bit_valid   (bit_valid),
    .bit_value   (bit_value),
    .minute_mark (minute_mark),
    .frame_ok    (frame_ok),
    .err         (err),
    .bit_count   (bit_count),
    .state_dbg   (state_dbg)
  );

  always #5 qzt_clk = ~qzt_clk;

  // ---------------- strobe monitor ----------------
  int   tick_idx = 0;
  int   n_vld = 0, n_mark = 0, n_err = 0;
  int   vld_tick = 0, err_tick = 0;
  logic last_val = 1'b0;
  logic ok_at_mark = 1'b0;
  int   cnt_at_mark = 0;
  int   bad_timing = 0, ok_alone = 0, err_mark = 0;
  logic prev_tick = 1'b0;

  always @(negedge qzt_clk) begin
    if (tick_1khz) tick_idx++;
    if (bit_valid) begin n_vld++; last_val = bit_value; vld_tick = tick_idx; end
    if (minute_mark) begin n_mark++; ok_at_mark = frame_ok; cnt_at_mark = int'(bit_count); end
    if (err) begin n_err++; err_tick = tick_idx; end
    if (frame_ok && !minute_mark) ok_alone++;
    if (err && minute_mark) err_mark++;
    // strobes must sit in the single cycle right after a tick cycle
    if ((bit_valid || minute_mark || frame_ok || err) && !prev_tick) bad_timing++;
    prev_tick = tick_1khz;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
  endtask

  task automatic do_tick(input logic lvl);
    sgn_in = lvl;
    @(posedge qzt_clk); #1; tick_1khz = 1'b1;
    @(posedge qzt_clk); #1; tick_1khz = 1'b0;
  endtask

  // kind: 0 = bit 0, 1 = bit 1, 2 = width error
  typedef struct {
    int hi;
    int lo;
    bit mark;
    bit ok;
    int kind;
    int cnt;
  } vec_t;

  vec_t vecs[$];
  int   mcnt = 0;

  function automatic void add(input int hi, input int lo, input bit mark, input bit ok, input int kind);
    vec_t v;
    if (mark) mcnt = 0;
    if (kind != 2 && mcnt < 63) mcnt++;
    v.hi = hi; v.lo = lo; v.mark = mark; v.ok = ok; v.kind = kind; v.cnt = mcnt;
    vecs.push_back(v);
  endfunction

  initial begin
    int s_vld, s_mark, s_err, t_first;

    // ---- table: frames of records ----
    // After reset: 100/900 and 200/800, then 57 short zeros -> 59 bits, but frame_bad from reset.
    add(100, 900, 0, 0, 0);
    add(200, 800, 0, 0, 1);
    for (int j = 2; j < 59; j++) add(40, (j == 58) ? 1600 : 6, 0, 0, 0);
    // F1: first marker after reset never ok; boundary widths 40/130/150/250; ends with 1900 gap.
    add(40, 6, 1, 0, 0);
    add(130, 6, 0, 0, 0);
    add(150, 6, 0, 0, 1);
    add(250, 6, 0, 0, 1);
    for (int j = 4; j < 59; j++) add((j % 8 == 0) ? 160 : 45, (j == 58) ? 1900 : 6, 0, 0, (j % 8 == 0) ? 1 : 0);
    // F2: clean frame -> ok; closing gap exactly at the marker threshold (1500).
    for (int j = 0; j < 59; j++) add((j % 10 == 5) ? 200 : 40, (j == 58) ? 1500 : 6, j == 0, 1, (j % 10 == 5) ? 1 : 0);
    // F3: marker ok from F2; 140, 39 and 251 ms pulses are errors; a 1499 gap is not a marker.
    add(100, 6, 1, 1, 0);
    add(140, 6, 0, 0, 2);
    add(39, 1499, 0, 0, 2);
    add(251, 6, 0, 0, 2);
    for (int j = 1; j < 59; j++) add((j % 7 == 3) ? 180 : 40, (j == 58) ? 1600 : 6, 0, 0, (j % 7 == 3) ? 1 : 0);
    // F4: marker not ok (errors in F3); only 58 bits follow.
    add(40, 6, 1, 0, 0);
    for (int j = 1; j < 58; j++) add(40, (j == 57) ? 1600 : 6, 0, 0, 0);
    // F5 start: marker not ok (58 bits).
    add(60, 6, 1, 0, 0);

    // ---- reset state ----
    #1;
    check("rst_bit_valid", 0, bit_valid, 0);
    check("rst_bit_value", 0, bit_value, 0);
    check("rst_minute_mark", 0, minute_mark, 0);
    check("rst_frame_ok", 0, frame_ok, 0);
    check("rst_err", 0, err, 0);
    check("rst_bit_count", 0, bit_count, 0);
    check("rst_state", 0, state_dbg, 0);
    repeat (3) @(posedge qzt_clk);
    #1; reset = 1'b0;

    // ---- bit 1 before reset, then reset asserted mid-HIGH ----
    repeat (10) do_tick(0);
    s_vld = n_vld;
    repeat (200) do_tick(1);
    repeat (20) do_tick(0);
    check("pre_vld", 0, n_vld - s_vld, 1);
    check("pre_val", 0, bit_value, 1);
    check("pre_cnt", 0, bit_count, 1);
    repeat (60) do_tick(1);
    check("pre_state_high", 0, state_dbg, 1);
    #2; reset = 1'b1;
    #1;
    check("mid_rst_state", 0, state_dbg, 0);
    check("mid_rst_bit_value", 0, bit_value, 0);
    check("mid_rst_bit_count", 0, bit_count, 0);
    check("mid_rst_strobes", 0, {bit_valid, minute_mark, frame_ok, err}, 0);
    sgn_in = 1'b0;
    repeat (4) @(posedge qzt_clk);
    #1; reset = 1'b0;
    repeat (10) do_tick(0);

    // ---- table run ----
    for (int i = 0; i < vecs.size(); i++) begin
      s_vld = n_vld; s_mark = n_mark; s_err = n_err;
      repeat (vecs[i].hi) do_tick(1);
      repeat (vecs[i].lo) do_tick(0);
      check("row_mark", i, n_mark - s_mark, vecs[i].mark ? 1 : 0);
      check("row_vld", i, n_vld - s_vld, (vecs[i].kind != 2) ? 1 : 0);
      check("row_err", i, n_err - s_err, (vecs[i].kind == 2) ? 1 : 0);
      check("row_bit_count", i, bit_count, vecs[i].cnt);
      check("row_state", i, state_dbg, 2);
      if (vecs[i].kind != 2) check("row_bit_value", i, last_val, vecs[i].kind);
      if (vecs[i].mark) begin
        check("row_frame_ok", i, ok_at_mark, vecs[i].ok);
        check("row_cnt_at_mark", i, cnt_at_mark, 0);
      end
    end

    // ---- glitches: 1-tick high in a gap, 1-tick low inside a 200 ms pulse ----
    s_vld = n_vld; s_mark = n_mark; s_err = n_err;
    repeat (150) do_tick(0);
    do_tick(1);
    repeat (150) do_tick(0);
    repeat (100) do_tick(1);
    do_tick(0);
    repeat (99) do_tick(1);
    repeat (300) do_tick(0);
    check("glitch_vld", 0, n_vld - s_vld, 1);
    check("glitch_val", 0, last_val, 1);
    check("glitch_err", 0, n_err - s_err, 0);
    check("glitch_mark", 0, n_mark - s_mark, 0);
    check("glitch_cnt", 0, bit_count, 2);

    // ---- timeout: low held 3 s in total ----
    s_err = n_err; s_mark = n_mark;
    repeat (2700) do_tick(0);
    check("tout_err", 0, n_err - s_err, 1);
    check("tout_err_tick", 0, err_tick - vld_tick, 2500);
    check("tout_state", 0, state_dbg, 0);
    check("tout_mark", 0, n_mark - s_mark, 0);
    check("tout_cnt", 0, bit_count, 2);

    // ---- first rise after timeout: nothing until the pulse completes ----
    s_vld = n_vld; s_mark = n_mark; s_err = n_err;
    t_first = tick_idx;
    repeat (100) do_tick(1);
    check("post_rise_mark", 0, n_mark - s_mark, 0);
    check("post_rise_vld", 0, n_vld - s_vld, 0);
    check("post_rise_state", 0, state_dbg, 1);
    repeat (10) do_tick(0);
    check("post_pulse_vld", 0, n_vld - s_vld, 1);
    check("post_pulse_val", 0, last_val, 0);
    check("post_pulse_err", 0, n_err - s_err, 0);
    check("post_pulse_state", 0, state_dbg, 2);
    check("post_pulse_ticks", 0, tick_idx - t_first, 110);

    // ---- global strobe rules ----
    check("strobe_timing", 0, bad_timing, 0);
    check("frame_ok_without_mark", 0, ok_alone, 0);
    check("err_with_mark", 0, err_mark, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dcf77_pulse_decoder.md
Name: dcf77_pulse_decoder

Overview:
Front-end stage that sits directly upstream of the temporary bit buffer and minute synchroniser. It samples the raw DCF77 demodulated signal on the 1 kHz tick, filters glitches and measures pulse and gap widths in milliseconds. Each second it emits one classified bit (0 = ~100 ms pulse, 1 = ~200 ms pulse), and it flags the minute marker (missing pulse at second 59). It also counts bits per frame so that downstream blocks receive a clean bit stream plus frame-integrity status.

Parameters:
ZERO_MIN, 40, minimum filtered high width (ms) accepted as bit 0
ZERO_MAX, 130, maximum high width (ms) accepted as bit 0
ONE_MIN, 150, minimum high width (ms) accepted as bit 1
ONE_MAX, 250, maximum high width (ms) accepted as bit 1
GAP_MIN, 1500, low width (ms) at or above which the next rising edge is a minute marker
TIMEOUT, 2500, low or high width (ms) that declares signal loss
CNT_W, 12, width of the ms counters (must hold TIMEOUT)

Ports:
qzt_clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
tick_1khz  in  1  one-qzt_clk-cycle enable, 1 kHz
sgn_in  in  1  raw DCF77 signal, asynchronous; high = pulse
bit_valid  out  1  one-cycle strobe: bit_value is valid
bit_value  out  1  decoded bit, held until the next bit_valid
minute_mark  out  1  one-cycle strobe at the rising edge that starts second 0
frame_ok  out  1  one-cycle strobe coincident with minute_mark when the frame was complete and error-free
err  out  1  one-cycle strobe on width violation or timeout
bit_count  out  6  bits accepted since the last minute_mark, saturates at 63
state_dbg  out  2  current FSM state (IDLE=0, HIGH=1, LOW=2)

Behaviour:
- Reset (async, active-high): all outputs are 0, FSM is IDLE, counters are 0, filter history is 0, and frame_bad is set to 1 (first partial frame is never ok).
- Synchroniser: two qzt_clk flops on sgn_in. All further logic advances only on cycles where tick_1khz=1.
- Filter: a 3-sample shift register on ticks; filt = majority of 3. A single-tick glitch is rejected. Filter latency is 2 ticks, identical on both edges, so widths are unaffected.
- Edge detection: rise/fall are computed from filt vs. the previous filt, on tick cycles only.
- width counter: cleared on every edge, incremented on every tick otherwise, and saturates at TIMEOUT.
- FSM:
  - IDLE: on rise -> HIGH. No bit and no mark is produced, because the preceding gap is unknown.
  - HIGH: on fall, classify width+1 (the falling tick counts):
    - ZERO_MIN..ZERO_MAX -> bit 0.
    - ONE_MIN..ONE_MAX -> bit 1.
    - In both cases, assert bit_valid and bit_count++ (saturating), then go to LOW.
    - Any other width -> err, set frame_bad, go to LOW.
    - If width reaches TIMEOUT -> err, set frame_bad, go to IDLE.
  - LOW: on rise:
    - If width+1 >= GAP_MIN: assert minute_mark. Assert frame_ok iff frame_bad=0 and bit_count==59. Then clear bit_count and frame_bad, and go to HIGH.
    - Otherwise go to HIGH.
    - If width reaches TIMEOUT -> err, set frame_bad, go to IDLE.
- Strobes: asserted for exactly the one qzt_clk cycle following the deciding tick. Outputs are registered. Total latency from raw edge to strobe is 2 qzt_clk (sync) + 2 ticks (filter) + 1 qzt_clk.
- bit_count != 59 at the marker (extra or missing bits): minute_mark still fires, frame_ok stays 0, and counting restarts.
- Simultaneous events: err and minute_mark never coincide. A timeout takes priority over an edge on the same tick.
- Reset mid-frame: the block returns to IDLE immediately. The first marker after reset never produces frame_ok.

Test Plan:
- Reset asserted mid-HIGH -> all outputs 0, state_dbg=0 the same cycle. After release, the first minute_mark has frame_ok=0.
- Pulses of 100 ms then 200 ms, separated by 900/800 ms gaps -> bit_valid twice with bit_value=0 then 1, and bit_count goes 1 then 2.
- A full frame of 59 valid pulses, then a 1900 ms gap, then a rise -> minute_mark=1, frame_ok=1 and bit_count=0 in the same cycle. A second full frame repeats this.
- A 1-tick high glitch inside a gap, plus a 1-tick low glitch inside a 200 ms pulse -> no extra edges, the bit decodes as 1, and no err.
- A 140 ms pulse -> err strobe, no bit_valid, and the next marker gives frame_ok=0. Separately, only 58 pulses before the marker -> frame_ok=0.
- sgn_in held low for 3 s -> err at the 2500th tick, state_dbg=0. The next rise yields neither a bit nor a mark until a valid pulse follows.
